fios_res_collector: RTL and testbench

FIOS_RES_COLLECTOR -- requirements
Module: fios_res_collector

---
 rtl/fios_res_collector.sv | 105 ++++++++++
 tb/tb_fios_res_collector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fios_res_collector.sv
// Collects a FIOS multiplier result word-serially (LS word first), subtracts the modulus
// on the fly and presents the reduced result (res - p if res >= p, else res) via valid/ready.
module fios_res_collector #(
    parameter int s = 8
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              res_valid_i,
    input  logic [16:0]       res_i,
    input  logic [16:0]       p_i,
    output logic              busy_o,
    output logic [s*17-1:0]   result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              overrun_o
);

    localparam int W     = 17;
    localparam int CNT_W = (s > 2) ? $clog2(s) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(s - 1);

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [s*W-1:0]     raw_q, raw_d;
    logic [s*W-1:0]     diff_q, diff_d;
    logic [s*W-1:0]     result_q, result_d;
    logic               overrun_q, overrun_d;

    logic               borrow_in;
    logic [17:0]        d;

    // The borrow chain restarts at word 0, so a stale borrow from a previous result never leaks in.
    assign borrow_in = (cnt_q == '0) ? 1'b0 : borrow_q;
    assign d         = {1'b0, res_i} - {1'b0, p_i} - {17'd0, borrow_in};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        raw_d     = raw_q;
        diff_d    = diff_q;
        result_d  = result_q;
        overrun_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (res_valid_i) begin
                    raw_d[cnt_q*W +: W]  = res_i;
                    diff_d[cnt_q*W +: W] = d[16:0];
                    borrow_d             = d[17];
                    if (cnt_q == LAST_IDX) begin
                        cnt_d    = '0;
                        state_d  = DONE;
                        // Final borrow set means res < p: keep the unreduced words.
                        result_d = d[17] ? raw_d : diff_d;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                overrun_d = res_valid_i;
                if (result_ready_i) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            // NOTE: the word buffers are cleared too, so a reset discards any partial result.
            raw_q     <= '0;
            diff_q    <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            raw_q     <= raw_d;
            diff_q    <= diff_d;
            result_q  <= result_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy_o         = (state_q == COLLECT) && (cnt_q != '0);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed self-checking bench for fios_res_collector with s=2 and hand-computed results.
module tb_fios_res_collector;

    localparam int S = 2;

    logic             clock_i = 1'b0;
    logic             reset_n_i = 1'b0;
    logic             res_valid_i = 1'b0;
    logic [16:0]      res_i = '0;
    logic [16:0]      p_i = '0;
    logic             busy_o;
    logic [S*17-1:0]  result_o;
    logic             result_valid_o;
    logic             result_ready_i = 1'b0;
    logic             overrun_o;

    int n_checks = 0;
    int n_fail   = 0;

    fios_res_collector #(.s(S)) dut (
        .clock_i        (clock_i),
        .reset_n_i      (reset_n_i),
        .res_valid_i    (res_valid_i),
        .res_i          (res_i),
        .p_i            (p_i),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .overrun_o      (overrun_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack2(input logic [16:0] w0, input logic [16:0] w1);
        return {30'd0, w1, w0};
    endfunction

    function automatic logic [63:0] res64();
        return {30'd0, result_o};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic send(input logic [16:0] r, input logic [16:0] p);
        res_valid_i = 1'b1;
        res_i       = r;
        p_i         = p;
        @(posedge clock_i);
        #1;
        res_valid_i = 1'b0;
    endtask

    task automatic accept();
        result_ready_i = 1'b1;
        idle(1);
        result_ready_i = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n_i = 1'b0;
        #2;
        check("rst_valid", {63'd0, result_valid_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_overrun", {63'd0, overrun_o}, 64'd0);
        check("rst_result", res64(), 64'd0);
        #2;
        reset_n_i = 1'b1;
        idle(1);
    endtask

    task automatic run_pair(input string tag,
                            input logic [16:0] r0, input logic [16:0] p0,
                            input logic [16:0] r1, input logic [16:0] p1,
                            input logic [16:0] e0, input logic [16:0] e1);
        send(r0, p0);
        check({tag, "_busy_w0"}, {63'd0, busy_o}, 64'd1);
        check({tag, "_valid_w0"}, {63'd0, result_valid_o}, 64'd0);
        send(r1, p1);
        check({tag, "_valid"}, {63'd0, result_valid_o}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, busy_o}, 64'd0);
        check({tag, "_result"}, res64(), pack2(e0, e1));
        accept();
        check({tag, "_valid_after"}, {63'd0, result_valid_o}, 64'd0);
    endtask

    initial begin
        idle(2);
        check("reset_valid", {63'd0, result_valid_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_result", res64(), 64'd0);
        check("reset_overrun", {63'd0, overrun_o}, 64'd0);
        reset_n_i = 1'b1;
        idle(1);

        run_pair("ge", 17'd7, 17'd5, 17'd0, 17'd0, 17'd2, 17'd0);
        run_pair("lt", 17'd3, 17'd5, 17'd0, 17'd0, 17'd3, 17'd0);
        run_pair("eq", 17'd5, 17'd5, 17'd0, 17'd0, 17'd0, 17'd0);
        run_pair("xborrow", 17'd0, 17'd1, 17'd1, 17'd0, 17'h1FFFF, 17'd0);

        // Backpressure with a dropped word in the 2nd stalled cycle.
        send(17'd7, 17'd5);
        send(17'd0, 17'd0);
        check("bp_c0_valid", {63'd0, result_valid_o}, 64'd1);
        idle(1);
        check("bp_c1_overrun", {63'd0, overrun_o}, 64'd0);
        send(17'd99, 17'd1);
        check("bp_c2_overrun", {63'd0, overrun_o}, 64'd1);
        check("bp_c2_valid", {63'd0, result_valid_o}, 64'd1);
        check("bp_c2_result", res64(), pack2(17'd2, 17'd0));
        idle(1);
        check("bp_c3_overrun", {63'd0, overrun_o}, 64'd0);
        check("bp_c3_valid", {63'd0, result_valid_o}, 64'd1);
        check("bp_c3_result", res64(), pack2(17'd2, 17'd0));
        check("bp_c3_busy", {63'd0, busy_o}, 64'd0);
        accept();
        run_pair("after_bp", 17'd9, 17'd4, 17'd0, 17'd0, 17'd5, 17'd0);

        // Word offered on the transfer cycle itself is dropped too.
        send(17'd7, 17'd5);
        send(17'd0, 17'd0);
        result_ready_i = 1'b1;
        send(17'd1, 17'd1);
        result_ready_i = 1'b0;
        check("xfer_drop_overrun", {63'd0, overrun_o}, 64'd1);
        check("xfer_drop_valid", {63'd0, result_valid_o}, 64'd0);
        check("xfer_drop_busy", {63'd0, busy_o}, 64'd0);
        run_pair("after_xfer", 17'd9, 17'd4, 17'd0, 17'd0, 17'd5, 17'd0);

        // Reset mid-collection discards the partial result.
        send(17'd3, 17'd1);
        check("mid_busy", {63'd0, busy_o}, 64'd1);
        pulse_reset();
        check("post_rst_busy", {63'd0, busy_o}, 64'd0);
        run_pair("post_rst", 17'd7, 17'd5, 17'd0, 17'd0, 17'd2, 17'd0);

        // Reset while a result is waiting.
        send(17'd8, 17'd5);
        send(17'd0, 17'd0);
        check("done_rst_pre", {63'd0, result_valid_o}, 64'd1);
        pulse_reset();
        check("done_rst_valid", {63'd0, result_valid_o}, 64'd0);

        // Idle gap between words.
        send(17'd7, 17'd5);
        idle(1);
        check("gap1_busy", {63'd0, busy_o}, 64'd1);
        check("gap1_valid", {63'd0, result_valid_o}, 64'd0);
        idle(1);
        check("gap2_busy", {63'd0, busy_o}, 64'd1);
        send(17'd0, 17'd0);
        check("gap_valid", {63'd0, result_valid_o}, 64'd1);
        check("gap_result", res64(), pack2(17'd2, 17'd0));
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
